// File: rtl/branch_target_predictor_if.sv
// Interface between the pipeline and the branch target predictor.
//   Fetch side : PCF in; PredTakenF / PredPCF out.
//   Execute side: ValidE, BranchE, PCE, PCTargetE, PCSrcE, PredTakenE, PredPCE in;
//                 MispredictE, FlushD, FlushE, CorrectPCE out.
// Modports: master = pipeline (drives lookup PC and resolution), slave = predictor.
interface branch_target_predictor_if;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredPCF;
    logic        ValidE;
    logic        BranchE;
    logic [31:0] PCE;
    logic [31:0] PCTargetE;
    logic        PCSrcE;
    logic        PredTakenE;
    logic [31:0] PredPCE;
    logic        MispredictE;
    logic        FlushD;
    logic        FlushE;
    logic [31:0] CorrectPCE;

    modport master (
        output PCF, ValidE, BranchE, PCE, PCTargetE, PCSrcE, PredTakenE, PredPCE,
        input  PredTakenF, PredPCF, MispredictE, FlushD, FlushE, CorrectPCE
    );

    modport slave (
        input  PCF, ValidE, BranchE, PCE, PCTargetE, PCSrcE, PredTakenE, PredPCE,
        output PredTakenF, PredPCF, MispredictE, FlushD, FlushE, CorrectPCE
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch history table + branch target buffer.
// Fetch-stage lookup is combinational on PCF; training happens at the rising
// edge from the resolved E-stage branch. Mispredict detection and the corrected
// fetch PC are produced combinationally from the E-stage inputs.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bp    - branch_target_predictor_if.slave (lookup, resolution, flush/redirect)
// Optional feature: define BP_TAG_EN to store and compare TAG_W-bit BTB tags,
// so aliasing PCs miss and a tag-mismatching update reloads the counter.
module branch_target_predictor #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned TAG_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    branch_target_predictor_if.slave    bp
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);

    localparam logic [CNT_W-1:0] CntWnt = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CntWt  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntMin = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_q    [ENTRIES];
    logic             valid_q  [ENTRIES];
    logic [31:0]      target_q [ENTRIES];

    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_e;
    logic             hit_f;
    logic             tag_miss_e;
    logic             upd_e;
    logic [CNT_W-1:0] cnt_e;
    logic [CNT_W-1:0] cnt_d;
    logic             pred_taken_f;
    logic             mispredict_e;

    assign idx_f = bp.PCF[IDX_W+1:2];
    assign idx_e = bp.PCE[IDX_W+1:2];
    assign upd_e = bp.ValidE & bp.BranchE;

`ifdef BP_TAG_EN
    logic [TAG_W-1:0] tag_q [ENTRIES];
    logic [TAG_W-1:0] tag_f;
    logic [TAG_W-1:0] tag_e;

    assign tag_f      = bp.PCF[IDX_W+2+:TAG_W];
    assign tag_e      = bp.PCE[IDX_W+2+:TAG_W];
    assign hit_f      = valid_q[idx_f] & (tag_q[idx_f] == tag_f);
    assign tag_miss_e = (tag_q[idx_e] != tag_e);
`else
    assign hit_f      = valid_q[idx_f];
    assign tag_miss_e = 1'b0;
`endif

    // Lookup reads the registered tables, so a same-cycle update to the same
    // index is only visible on the following cycle.
    assign pred_taken_f  = hit_f & cnt_q[idx_f][CNT_W-1];
    assign bp.PredTakenF = pred_taken_f;
    assign bp.PredPCF    = pred_taken_f ? target_q[idx_f] : (bp.PCF + 32'd4);

    assign cnt_e = cnt_q[idx_e];

    always_comb begin
        cnt_d = cnt_e;
        if (tag_miss_e) begin
            // A different branch now owns this slot: restart from a weak state.
            cnt_d = bp.PCSrcE ? CntWt : CntWnt;
        end else if (bp.PCSrcE) begin
            cnt_d = (cnt_e == CntMax) ? cnt_e : cnt_e + CNT_W'(1);
        end else begin
            cnt_d = (cnt_e == CntMin) ? cnt_e : cnt_e - CNT_W'(1);
        end
    end

    // A taken branch with the right direction but a stale target still
    // redirects fetch. Forced low while in reset.
    assign mispredict_e = rst_n & upd_e &
                          ((bp.PredTakenE != bp.PCSrcE) |
                           (bp.PredTakenE & bp.PCSrcE & (bp.PredPCE != bp.PCTargetE)));

    assign bp.MispredictE = mispredict_e;
    assign bp.FlushD      = mispredict_e;
    assign bp.FlushE      = mispredict_e;
    assign bp.CorrectPCE  = bp.PCSrcE ? bp.PCTargetE : (bp.PCE + 32'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                cnt_q[i]    <= CntWnt;
                valid_q[i]  <= 1'b0;
                target_q[i] <= 32'd0;
`ifdef BP_TAG_EN
                tag_q[i]    <= '0;
`endif
            end
        end else if (upd_e) begin
            cnt_q[idx_e] <= cnt_d;
            if (bp.PCSrcE) begin
                valid_q[idx_e]  <= 1'b1;
                target_q[idx_e] <= bp.PCTargetE;
`ifdef BP_TAG_EN
                tag_q[idx_e]    <= tag_e;
`endif
            end
        end
    end
endmodule

// File: tb/tb_branch_target_predictor.sv
module tb_branch_target_predictor;
    logic clk;
    logic rst_n;

    branch_target_predictor_if bp_if ();

    branch_target_predictor #(
        .ENTRIES(64),
        .CNT_W  (2),
        .TAG_W  (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bp   (bp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pcf;
        logic        vld;
        logic        br;
        logic [31:0] pce;
        logic [31:0] tgt;
        logic        src;
        logic        pte;
        logic [31:0] ppe;
        logic        e_pt;
        logic [31:0] e_ppc;
        logic        e_misp;
        logic [31:0] e_cpc;
    } vec_t;

    typedef struct {
        logic        pt;
        logic [31:0] ppc;
        logic        misp;
        logic [31:0] cpc;
        string       name;
    } exp_t;

`ifdef BP_TAG_EN
    localparam bit TagEn = 1'b1;
`else
    localparam bit TagEn = 1'b0;
`endif

    localparam int NVec = 21;
    vec_t vecs [NVec];
    exp_t sb_q [$];
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bp_if.PCF        = v.pcf;
        bp_if.ValidE     = v.vld;
        bp_if.BranchE    = v.br;
        bp_if.PCE        = v.pce;
        bp_if.PCTargetE  = v.tgt;
        bp_if.PCSrcE     = v.src;
        bp_if.PredTakenE = v.pte;
        bp_if.PredPCE    = v.ppe;
    endtask

    task automatic push_exp(input logic pt, input logic [31:0] ppc, input logic misp,
                            input logic [31:0] cpc, input string name);
        exp_t e;
        e.pt   = pt;
        e.ppc  = ppc;
        e.misp = misp;
        e.cpc  = cpc;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb_q.pop_front();
        chk({e.name, ".PredTakenF"}, {31'd0, bp_if.PredTakenF}, {31'd0, e.pt});
        chk({e.name, ".PredPCF"}, bp_if.PredPCF, e.ppc);
        chk({e.name, ".MispredictE"}, {31'd0, bp_if.MispredictE}, {31'd0, e.misp});
        chk({e.name, ".FlushD"}, {31'd0, bp_if.FlushD}, {31'd0, e.misp});
        chk({e.name, ".FlushE"}, {31'd0, bp_if.FlushE}, {31'd0, e.misp});
        chk({e.name, ".CorrectPCE"}, bp_if.CorrectPCE, e.cpc);
    endtask

    task automatic apply(input vec_t v, input string name);
        drive(v);
        push_exp(v.e_pt, v.e_ppc, v.e_misp, v.e_cpc, name);
        #1;
        pop_check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;

        // pcf, vld, br, pce, tgt, src, pte, ppe, e_pt, e_ppc, e_misp, e_cpc
        vecs[0]  = '{32'h100, 0, 0, 32'h000, 32'h000, 0, 0, 32'h000, 0, 32'h104, 0, 32'h004};
        vecs[1]  = '{32'h100, 1, 1, 32'h100, 32'h200, 1, 0, 32'h104, 0, 32'h104, 1, 32'h200};
        vecs[2]  = '{32'h100, 1, 1, 32'h100, 32'h200, 1, 0, 32'h104, 1, 32'h200, 1, 32'h200};
        vecs[3]  = '{32'h100, 0, 0, 32'h100, 32'h200, 0, 0, 32'h000, 1, 32'h200, 0, 32'h104};
        // four not-taken updates from saturated 3
        vecs[4]  = '{32'h100, 1, 1, 32'h100, 32'h200, 0, 1, 32'h200, 1, 32'h200, 1, 32'h104};
        vecs[5]  = '{32'h100, 1, 1, 32'h100, 32'h200, 0, 1, 32'h200, 1, 32'h200, 1, 32'h104};
        vecs[6]  = '{32'h100, 1, 1, 32'h100, 32'h200, 0, 1, 32'h200, 0, 32'h104, 1, 32'h104};
        vecs[7]  = '{32'h100, 1, 1, 32'h100, 32'h200, 0, 0, 32'h104, 0, 32'h104, 0, 32'h104};
        vecs[8]  = '{32'h100, 0, 0, 32'h100, 32'h200, 0, 0, 32'h000, 0, 32'h104, 0, 32'h104};
        // bubble and non-branch must neither flush nor train
        vecs[9]  = '{32'h100, 0, 1, 32'h100, 32'h300, 1, 0, 32'h104, 0, 32'h104, 0, 32'h300};
        vecs[10] = '{32'h100, 1, 0, 32'h100, 32'h300, 1, 0, 32'h104, 0, 32'h104, 0, 32'h300};
        vecs[11] = '{32'h100, 1, 1, 32'h100, 32'h200, 1, 0, 32'h104, 0, 32'h104, 1, 32'h200};
        vecs[12] = '{32'h100, 1, 1, 32'h100, 32'h200, 1, 0, 32'h104, 0, 32'h104, 1, 32'h200};
        // taken, predicted taken, wrong target
        vecs[13] = '{32'h100, 1, 1, 32'h100, 32'h240, 1, 1, 32'h200, 1, 32'h200, 1, 32'h240};
        vecs[14] = '{32'h100, 0, 0, 32'h100, 32'h240, 0, 0, 32'h000, 1, 32'h240, 0, 32'h104};
        vecs[15] = '{32'h100, 1, 1, 32'h100, 32'h240, 1, 1, 32'h240, 1, 32'h240, 0, 32'h240};
        vecs[16] = '{32'hFFFF_FFFC, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h4};
        if (TagEn) begin
            vecs[17] = '{32'h200, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 32'h204, 0, 32'h4};
        end else begin
            vecs[17] = '{32'h200, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 1, 32'h240, 0, 32'h4};
        end
        vecs[18] = '{32'h104, 0, 0, 32'h104, 32'h0, 0, 0, 32'h0, 0, 32'h108, 0, 32'h108};
        vecs[19] = '{32'h104, 1, 1, 32'h104, 32'h400, 0, 0, 32'h108, 0, 32'h108, 0, 32'h108};
        vecs[20] = '{32'h104, 0, 0, 32'h104, 32'h400, 0, 0, 32'h0, 0, 32'h108, 0, 32'h108};

        rst_n = 1'b0;
        v = vecs[0];
        drive(v);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVec; i++) begin
            @(negedge clk);
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of a live taken update.
        @(negedge clk);
        v = '{32'h100, 1, 1, 32'h100, 32'h500, 1, 0, 32'h104, 0, 32'h0, 0, 32'h0};
        drive(v);
        #2;
        rst_n = 1'b0;
        #1;
        push_exp(1'b0, 32'h104, 1'b0, 32'h500, "rst_async");
        pop_check();
        @(posedge clk);
        #1;
        push_exp(1'b0, 32'h104, 1'b0, 32'h500, "rst_held");
        pop_check();
        // Release with the update still present: it commits on the next edge,
        // and a single taken step from weakly-not-taken must predict taken.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        push_exp(1'b0, 32'h104, 1'b1, 32'h500, "rst_release");
        pop_check();
        @(negedge clk);
        v = '{32'h100, 0, 0, 32'h100, 32'h500, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0};
        drive(v);
        #1;
        push_exp(1'b1, 32'h500, 1'b0, 32'h104, "post_rst_train");
        pop_check();
        @(negedge clk);
        v.pcf = 32'h104;
        drive(v);
        #1;
        push_exp(1'b0, 32'h108, 1'b0, 32'h104, "post_rst_other");
        pop_check();

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 Parameter: ENTRIES, default 64, number of BHT/BTB entries; power of two, 4..1024.
REQ-002 Parameter: CNT_W, default 2, saturating-counter width; 2..4.
REQ-003 Parameter: TAG_W, default 8, BTB tag width; used only when BP_TAG_EN is defined.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 PCF  input  32  fetch-stage PC to look up.
REQ-007 PredTakenF  output  1  prediction for PCF: 1 = taken.
REQ-008 PredPCF  output  32  predicted next PC for PCF.
REQ-009 ValidE  input  1  E-stage slot holds a live instruction (not bubble, not stalled).
REQ-010 BranchE  input  1  E-stage instruction is a conditional branch.
REQ-011 PCE  input  32  E-stage instruction PC.
REQ-012 PCTargetE  input  32  resolved branch target.
REQ-013 PCSrcE  input  1  resolved outcome: 1 = taken.
REQ-014 PredTakenE  input  1  PredTakenF, piped to E with the instruction.
REQ-015 PredPCE  input  32  PredPCF, piped to E with the instruction.
REQ-016 MispredictE  output  1  E-stage branch mispredicted.
REQ-017 FlushD  output  1  flush Decode register.
REQ-018 FlushE  output  1  flush Execute register.
REQ-019 CorrectPCE  output  32  PC the fetch stage loads when MispredictE = 1.

Function
REQ-020 Index = PC[IDX_W+1:2], IDX_W = log2(ENTRIES); PC[1:0] ignored.
REQ-021 Per entry: CNT_W-bit counter, 1-bit valid, 32-bit target, TAG_W-bit tag (tag only with BP_TAG_EN).
REQ-022 Lookup combinational on PCF, zero latency; hit = valid[idx] (AND tag match with BP_TAG_EN).
REQ-023 PredTakenF = hit AND counter MSB = 1; PredPCF = target[idx] when PredTakenF, else PCF+4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000).
REQ-024 Update when ValidE AND BranchE only, at rising edge; otherwise no state changes.
REQ-025 Counter: PCSrcE=1 increments, saturating at 2^CNT_W-1; PCSrcE=0 decrements, saturating at 0.
REQ-026 On PCSrcE=1: target <= PCTargetE, valid <= 1, tag <= PCE tag bits; on PCSrcE=0 target/valid/tag unchanged.
REQ-027 On update to an entry whose tag mismatches (BP_TAG_EN): counter reloads to weakly-taken 2^(CNT_W-1) if taken, weakly-not-taken 2^(CNT_W-1)-1 if not taken, instead of REQ-025.
REQ-028 MispredictE = ValidE AND BranchE AND ((PredTakenE != PCSrcE) OR (PredTakenE AND PCSrcE AND PredPCE != PCTargetE)); combinational.
REQ-029 CorrectPCE = PCTargetE when PCSrcE=1, else PCE+4.
REQ-030 FlushD = FlushE = MispredictE.
REQ-031 Same-index lookup and update in one cycle: lookup returns pre-update contents; no bypass.
REQ-032 Non-branch or ValidE=0: MispredictE, FlushD, FlushE = 0; tables untouched.

Reset
REQ-033 rst_n low: all counters <= 2^(CNT_W-1)-1, all valid <= 0, targets <= 0, tags <= 0, immediately, independent of clk.
REQ-034 Outputs during reset: PredTakenF=0, PredPCF=PCF+4, MispredictE/FlushD/FlushE=0.
REQ-035 Update coinciding with reset assertion is discarded; first update is the first rising edge with rst_n high.

Configuration
REQ-036 Macro BP_TAG_EN defined: tag array stored and compared (REQ-022, REQ-027); aliasing PCs miss.
REQ-037 BP_TAG_EN undefined: no tag storage; hit = valid only; aliasing PCs share entry; REQ-027 inactive.

Verification
REQ-038 Reset, PCF=0x100 -> PredTakenF=0, PredPCF=0x104.
REQ-039 Branch PCE=0x100 resolved taken to 0x200 twice (PredTakenE=0) -> MispredictE=1 both, CorrectPCE=0x200; then PCF=0x100 -> PredTakenF=1, PredPCF=0x200.
REQ-040 Entry saturated at 3, four not-taken updates -> counter 2,1,0,0; PredTakenF 1,0,0,0 after each; no underflow.
REQ-041 PredTakenE=1, PredPCE=0x200, PCSrcE=1, PCTargetE=0x240 -> MispredictE=1, FlushD=FlushE=1, CorrectPCE=0x240, target updated to 0x240.
REQ-042 ENTRIES=64, PCs 0x100 and 0x200 (same index): with BP_TAG_EN, train 0x100 taken -> lookup 0x200 PredTakenF=0; without, PredTakenF=1.
REQ-043 rst_n pulsed low mid-run with ValidE=BranchE=1 -> all entries back to weakly-not-taken, valid=0, no update committed.
